// File: rtl/seg_display_driver.sv
// Multiplexed common-anode 7-segment driver for the 12-bit status-digit bus.
// Latency: outputs are registered, one cycle behind the scan counters.
// Backpressure: none; digits are sampled only at frame boundaries, never stalled.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   digits_in    - 4*NUM_DIGITS hex digits; nibble k drives digit k (0 = rightmost)
//   dp_in        - per-digit decimal point, active-high
//   brightness   - PWM level, 15 = full on, 0 = 1/16 duty
//   enable       - 0 blanks the display; scan counters keep running
//   blink        - blink request (only honoured when SEG_BLINK_EN is defined)
//   seg_out      - active-low segments {dp,g,f,e,d,c,b,a}
//   sel_out      - active-low digit enables, one-hot-low or all ones
//   frame_done   - one-cycle pulse after each shadow snapshot load
//
// Build option: define SEG_BLINK_EN to enable the frame-counter driven blink.

module seg_display_driver #(
    parameter int NUM_DIGITS = 3,
    parameter int DIV_BITS   = 16   // slot = 2^DIV_BITS cycles; must be >= 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [3:0]                brightness,
    input  logic                      enable,
    input  logic                      blink,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     sel_out,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // One snapshot of everything the display shows for a whole frame.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;

    logic [DIV_BITS-1:0] div_cnt;
    logic [IDX_W-1:0]    idx;
    frame_t              shadow;

    logic                slot_wrap;
    logic                frame_bnd;
    logic                blank_phase;
    logic                lit;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [6:0]          cur_seg;
    logic [NUM_DIGITS-1:0] sel_nxt;

    // Hex to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexseg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_wrap = &div_cnt;
    assign frame_bnd = slot_wrap && (idx == LAST_IDX);

    // Scan counters and frame snapshot. The snapshot is the only place the
    // digit/dp inputs are sampled, so a frame can never show a torn value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            idx        <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= div_cnt + DIV_BITS'(1);
            frame_done <= frame_bnd;
            if (slot_wrap) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            if (frame_bnd) begin
                shadow.digits <= digits_in;
                shadow.dp     <= dp_in;
            end
        end
    end

`ifdef SEG_BLINK_EN
    // Frame counter: bit 6 toggles every 64 frames, giving the blink period.
    logic [6:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_bnd) begin
            frame_cnt <= frame_cnt + 7'd1;
        end
    end

    assign blank_phase = blink && frame_cnt[6];
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign blank_phase  = 1'b0;
`endif

    // The first 16 cycles of each slot stay dark so the previous digit's
    // segment pattern cannot ghost onto the next digit while drivers settle.
    // PWM: the top nibble of the slot counter is compared against brightness.
    assign lit = enable
              && (div_cnt >= DIV_BITS'(16))
              && (div_cnt[DIV_BITS-1 -: 4] <= brightness)
              && !blank_phase;

    assign cur_nib = shadow.digits[idx*4 +: 4];
    assign cur_dp  = shadow.dp[idx];
    assign cur_seg = hexseg(cur_nib);

    always_comb begin
        sel_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_nxt[k] = !(lit && (idx == IDX_W'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= '1;
            sel_out <= '1;
        end else begin
            sel_out <= sel_nxt;
            seg_out <= lit ? {~cur_dp, cur_seg} : 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] digits_in;
    logic [2:0]  dp_in;
    logic [3:0]  brightness;
    logic        enable;
    logic        blink;
    logic [7:0]  seg_out;
    logic [2:0]  sel_out;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;   // posedges since the last frame boundary (or reset release)

    always #5 clk = ~clk;

    seg_display_driver #(
        .NUM_DIGITS (3),
        .DIV_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .brightness (brightness),
        .enable     (enable),
        .blink      (blink),
        .seg_out    (seg_out),
        .sel_out    (sel_out),
        .frame_done (frame_done)
    );

    // Outputs sampled at negedge after pos posedges reflect counter value pos-1.
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        pos += n;
    endtask

    task automatic wait_frame(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (frame_done !== 1'b1 && t < 1000);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_frame_timeout: frame_done=%b after %0d cycles, want 1", tag, frame_done, t);
        end
        pos = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (seg_out !== 8'hFF || sel_out !== 3'b111 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: seg=%h sel=%b fd=%b want FF/111/0", seg_out, sel_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        adv(300);   // counter 299: slot 1, div 43, shadow still zero
        n_checks++;
        if (sel_out !== 3'b101 || seg_out !== 8'hC0) begin
            n_fail++;
            $display("FAIL pre_midreset: sel=%b seg=%h want 101/C0", sel_out, seg_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_out !== 8'hFF || sel_out !== 3'b111 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: seg=%h sel=%b fd=%b want FF/111/0", seg_out, sel_out, frame_done);
        end
        digits_in = 12'h3A7;
        dp_in     = 3'b010;
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        adv(5);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL post_reset_guard: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        adv(15);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hC0) begin
            n_fail++;
            $display("FAIL post_reset_zero: sel=%b seg=%h want 110/C0", sel_out, seg_out);
        end
        adv(747);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fd_early_767: fd=%b want 0", frame_done);
        end
        adv(1);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL fd_at_768: fd=%b want 1", frame_done);
        end
        pos = 0;
    endtask

    task automatic test_frame_decode();
        adv(1);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fd_one_cycle: fd=%b want 0", frame_done);
        end
        adv(15);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL s0_guard: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        adv(1);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hF8) begin
            n_fail++;
            $display("FAIL s0_first_lit: sel=%b seg=%h want 110/F8", sel_out, seg_out);
        end
        adv(256 - pos);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hF8) begin
            n_fail++;
            $display("FAIL s0_last: sel=%b seg=%h want 110/F8", sel_out, seg_out);
        end
        adv(272 - pos);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL s1_guard: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        adv(1);
        n_checks++;
        if (sel_out !== 3'b101 || seg_out !== 8'h08) begin
            n_fail++;
            $display("FAIL s1_lit: sel=%b seg=%h want 101/08", sel_out, seg_out);
        end
        adv(713 - pos);
        n_checks++;
        if (sel_out !== 3'b011 || seg_out !== 8'hB0) begin
            n_fail++;
            $display("FAIL s2_lit: sel=%b seg=%h want 011/B0", sel_out, seg_out);
        end
    endtask

    task automatic test_midframe_change();
        digits_in = 12'h111;
        dp_in     = 3'b000;
        wait_frame("mid_a");
        adv(100);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hF9) begin
            n_fail++;
            $display("FAIL mid_s0: sel=%b seg=%h want 110/F9", sel_out, seg_out);
        end
        digits_in = 12'h222;
        adv(357 - pos);
        n_checks++;
        if (sel_out !== 3'b101 || seg_out !== 8'hF9) begin
            n_fail++;
            $display("FAIL mid_s1_old: sel=%b seg=%h want 101/F9", sel_out, seg_out);
        end
        adv(713 - pos);
        n_checks++;
        if (sel_out !== 3'b011 || seg_out !== 8'hF9) begin
            n_fail++;
            $display("FAIL mid_s2_old: sel=%b seg=%h want 011/F9", sel_out, seg_out);
        end
        wait_frame("mid_b");
        adv(17);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL mid_new: sel=%b seg=%h want 110/A4", sel_out, seg_out);
        end
    endtask

    task automatic test_brightness();
        wait_frame("bri");
        brightness = 4'd3;
        adv(16);
        n_checks++;
        if (sel_out !== 3'b111) begin
            n_fail++;
            $display("FAIL bri3_c15: sel=%b want 111", sel_out);
        end
        adv(1);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL bri3_c16: sel=%b seg=%h want 110/A4", sel_out, seg_out);
        end
        adv(47);
        n_checks++;
        if (sel_out !== 3'b110) begin
            n_fail++;
            $display("FAIL bri3_c63: sel=%b want 110", sel_out);
        end
        adv(1);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL bri3_c64: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        adv(100);
        n_checks++;
        if (sel_out !== 3'b111) begin
            n_fail++;
            $display("FAIL bri3_c164: sel=%b want 111", sel_out);
        end
        adv(273 - pos);
        n_checks++;
        if (sel_out !== 3'b101) begin
            n_fail++;
            $display("FAIL bri3_s1: sel=%b want 101", sel_out);
        end
        brightness = 4'd0;
        adv(529 - pos);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL bri0_c16: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        adv(30);
        n_checks++;
        if (sel_out !== 3'b111) begin
            n_fail++;
            $display("FAIL bri0_c46: sel=%b want 111", sel_out);
        end
        brightness = 4'd15;
        adv(1);
        n_checks++;
        if (sel_out !== 3'b011 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL bri15_next: sel=%b seg=%h want 011/A4", sel_out, seg_out);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        adv(1);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL en0_next: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        wait_frame("en0");
        adv(100);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL en0_dark: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        adv(767 - pos);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL en0_fd767: fd=%b want 0", frame_done);
        end
        adv(1);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL en0_fd768: fd=%b want 1", frame_done);
        end
        pos = 0;
        adv(100);
        n_checks++;
        if (sel_out !== 3'b111) begin
            n_fail++;
            $display("FAIL en0_dark2: sel=%b want 111", sel_out);
        end
        enable = 1'b1;
        adv(1);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL en1_restore: sel=%b seg=%h want 110/A4", sel_out, seg_out);
        end
    endtask

    task automatic test_blink();
`ifdef SEG_BLINK_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        blink = 1'b1;
        pos = 0;
        adv(101);
        n_checks++;
        if (sel_out !== 3'b110) begin
            n_fail++;
            $display("FAIL blink_f0: sel=%b want 110", sel_out);
        end
        for (int f = 1; f <= 63; f++) wait_frame("blink_lit");
        adv(100);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL blink_f63: sel=%b seg=%h want 110/A4", sel_out, seg_out);
        end
        wait_frame("blink_64");
        adv(100);
        n_checks++;
        if (sel_out !== 3'b111 || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL blink_f64: sel=%b seg=%h want 111/FF", sel_out, seg_out);
        end
        blink = 1'b0;
        adv(1);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL blink_off: sel=%b seg=%h want 110/A4", sel_out, seg_out);
        end
`else
        blink = 1'b1;
        wait_frame("blink_ign");
        adv(100);
        n_checks++;
        if (sel_out !== 3'b110 || seg_out !== 8'hA4) begin
            n_fail++;
            $display("FAIL blink_ignored: sel=%b seg=%h want 110/A4", sel_out, seg_out);
        end
        blink = 1'b0;
`endif
    endtask

    initial begin
        rst_n      = 1'b1;
        digits_in  = 12'h000;
        dp_in      = 3'b000;
        brightness = 4'd15;
        enable     = 1'b1;
        blink      = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        test_reset();
        test_frame_decode();
        test_midframe_change();
        test_brightness();
        test_enable();
        test_blink();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
